// File: rtl/counter_fsm_mod.sv
// Up/down counter with programmable terminal value, synchronous load and
// selectable boundary behaviour (wrap / saturate / trap), all outputs registered.
module counter_fsm_mod #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] limit,
  input  logic [1:0]   mode,
  input  logic         clr_ovf,
  output logic [N-1:0] count,
  output logic [1:0]   state,
  output logic         tc,
  output logic         ovflw
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;
  localparam logic [1:0] S_TRAP = 2'd3;

  localparam logic [1:0] M_SAT  = 2'b01;
  localparam logic [1:0] M_TRAP = 2'b10;

  logic [1:0]   state_n;
  logic [N-1:0] count_n;
  logic         tc_n;
  logic         ovflw_n;
  logic         at_top;
  logic         at_bot;
  logic         step;
  logic         boundary;

  // at_top uses >= so a limit lowered below count still triggers a boundary
  assign at_top   = (count >= limit);
  assign at_bot   = (count == '0);
  assign step     = !load && (state != S_TRAP) && en;
  assign boundary = step && (up_dn ? at_top : at_bot);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      tc    <= 1'b0;
      ovflw <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      tc    <= tc_n;
      ovflw <= ovflw_n;
    end
  end

  always_comb begin
    state_n = state;
    if (load)
      state_n = S_IDLE;
    else if (state == S_TRAP)
      state_n = clr_ovf ? S_IDLE : S_TRAP;
    else if (!en)
      state_n = S_IDLE;
    else if (up_dn)
      state_n = (at_top && mode == M_TRAP) ? S_TRAP : S_UP;
    else
      state_n = (at_bot && mode == M_TRAP) ? S_TRAP : S_DOWN;
  end

  always_comb begin
    count_n = count;
    tc_n    = boundary;
    ovflw_n = boundary ? 1'b1 : (clr_ovf ? 1'b0 : ovflw);
    if (load) begin
      count_n = (load_val > limit) ? limit : load_val;
    end else if (step) begin
      if (up_dn) begin
        if (!at_top)
          count_n = count + N'(1);
        else if (mode == M_SAT || mode == M_TRAP)
          count_n = limit;
        else
          count_n = '0;
      end else begin
        if (!at_bot)
          count_n = count - N'(1);
        else if (mode == M_SAT || mode == M_TRAP)
          count_n = '0;
        else
          count_n = limit;
      end
    end
  end

endmodule

// File: tb/tb_counter_fsm_mod.sv
// Directed-vector bench for counter_fsm_mod: the driver pushes hand-computed
// expectations into a queue, a monitor pops one after every clock edge.
`timescale 1ns/1ps
module tb_counter_fsm_mod;
  localparam int N = 8;
  localparam int W = N + 4;

  logic         clk;
  logic         reset;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] limit;
  logic [1:0]   mode;
  logic         clr_ovf;
  logic [N-1:0] count;
  logic [1:0]   state;
  logic         tc;
  logic         ovflw;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec;
  int           n_err;

  counter_fsm_mod #(.N(N)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .limit(limit), .mode(mode), .clr_ovf(clr_ovf),
    .count(count), .state(state), .tc(tc), .ovflw(ovflw)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic compare(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got count=%0d state=%0d tc=%0b ovflw=%0b, expected count=%0d state=%0d tc=%0b ovflw=%0b",
               nm, got[W-1:4], got[3:2], got[1], got[0], exp[W-1:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // monitor: outputs are valid one step after each edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      compare(nm, {count, state, tc, ovflw}, e);
    end
  end

  // driver: apply one vector for one edge and queue its expected result
  task automatic drive(input string nm, input logic e, input logic u, input logic l,
                       input logic [N-1:0] lv, input logic [N-1:0] lim,
                       input logic [1:0] m, input logic c,
                       input logic [N-1:0] ec, input logic [1:0] es,
                       input logic et, input logic eo);
    @(negedge clk);
    en = e; up_dn = u; load = l; load_val = lv; limit = lim; mode = m; clr_ovf = c;
    exp_q.push_back({ec, es, et, eo});
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; en = 0; up_dn = 0; load = 0; load_val = '0; limit = '0; mode = 2'b00; clr_ovf = 0;
    #22;
    compare("reset_state", {count, state, tc, ovflw}, {8'd0, 2'd0, 1'b0, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    // wrap up
    drive("wrap_load",  0,1,1, 8'd0, 8'd5, 2'b00, 0,  8'd0, 2'd0, 0, 0);
    drive("wrap_1",     1,1,0, 8'd0, 8'd5, 2'b00, 0,  8'd1, 2'd1, 0, 0);
    drive("wrap_2",     1,1,0, 8'd0, 8'd5, 2'b00, 0,  8'd2, 2'd1, 0, 0);
    drive("wrap_3",     1,1,0, 8'd0, 8'd5, 2'b00, 0,  8'd3, 2'd1, 0, 0);
    drive("wrap_4",     1,1,0, 8'd0, 8'd5, 2'b00, 0,  8'd4, 2'd1, 0, 0);
    drive("wrap_5",     1,1,0, 8'd0, 8'd5, 2'b00, 0,  8'd5, 2'd1, 0, 0);
    drive("wrap_0",     1,1,0, 8'd0, 8'd5, 2'b00, 0,  8'd0, 2'd1, 1, 1);
    drive("wrap_1b",    1,1,0, 8'd0, 8'd5, 2'b00, 0,  8'd1, 2'd1, 0, 1);
    drive("wrap_clr",   0,1,0, 8'd0, 8'd5, 2'b00, 1,  8'd1, 2'd0, 0, 0);

    // saturate down
    drive("sat_load",   0,0,1, 8'd3, 8'd9, 2'b01, 0,  8'd3, 2'd0, 0, 0);
    drive("sat_2",      1,0,0, 8'd0, 8'd9, 2'b01, 0,  8'd2, 2'd2, 0, 0);
    drive("sat_1",      1,0,0, 8'd0, 8'd9, 2'b01, 0,  8'd1, 2'd2, 0, 0);
    drive("sat_0",      1,0,0, 8'd0, 8'd9, 2'b01, 0,  8'd0, 2'd2, 0, 0);
    drive("sat_0b",     1,0,0, 8'd0, 8'd9, 2'b01, 0,  8'd0, 2'd2, 1, 1);
    drive("sat_0c",     1,0,0, 8'd0, 8'd9, 2'b01, 0,  8'd0, 2'd2, 1, 1);
    drive("sat_clr",    0,0,0, 8'd0, 8'd9, 2'b01, 1,  8'd0, 2'd0, 0, 0);

    // trap and release
    drive("trap_load",  0,1,1, 8'd2, 8'd3, 2'b10, 0,  8'd2, 2'd0, 0, 0);
    drive("trap_up3",   1,1,0, 8'd0, 8'd3, 2'b10, 0,  8'd3, 2'd1, 0, 0);
    drive("trap_enter", 1,1,0, 8'd0, 8'd3, 2'b10, 0,  8'd3, 2'd3, 1, 1);
    drive("trap_hold1", 1,1,0, 8'd0, 8'd3, 2'b10, 0,  8'd3, 2'd3, 0, 1);
    drive("trap_hold2", 1,1,0, 8'd0, 8'd3, 2'b10, 0,  8'd3, 2'd3, 0, 1);
    drive("trap_dn_ig", 1,0,0, 8'd0, 8'd3, 2'b10, 0,  8'd3, 2'd3, 0, 1);
    drive("trap_rel",   1,1,0, 8'd0, 8'd3, 2'b10, 1,  8'd3, 2'd0, 0, 0);
    drive("trap_again", 1,1,0, 8'd0, 8'd3, 2'b10, 0,  8'd3, 2'd3, 1, 1);

    // load priority and clamp
    drive("load_trap",  1,1,1, 8'd4, 8'd10, 2'b10, 0, 8'd4, 2'd0, 0, 1);
    drive("load_clamp", 1,1,1, 8'd200, 8'd10, 2'b10, 0, 8'd10, 2'd0, 0, 1);

    // clear/set collision
    drive("clr_coll",   1,1,0, 8'd0, 8'd10, 2'b00, 1, 8'd0, 2'd1, 1, 1);
    drive("clr_later",  1,1,0, 8'd0, 8'd10, 2'b00, 1, 8'd1, 2'd1, 0, 0);

    // limit == 0
    drive("lim0_load",  0,1,1, 8'd0, 8'd0, 2'b01, 0, 8'd0, 2'd0, 0, 0);
    drive("lim0_up",    1,1,0, 8'd0, 8'd0, 2'b01, 0, 8'd0, 2'd1, 1, 1);
    drive("lim0_dn",    1,0,0, 8'd0, 8'd0, 2'b00, 0, 8'd0, 2'd2, 1, 1);

    // limit lowered below count
    drive("low_load",   0,1,1, 8'd8, 8'd10, 2'b00, 1, 8'd8, 2'd0, 0, 0);
    drive("low_up",     1,1,0, 8'd0, 8'd5,  2'b00, 0, 8'd0, 2'd1, 1, 1);
    drive("low_load2",  0,1,1, 8'd8, 8'd10, 2'b00, 1, 8'd8, 2'd0, 0, 0);
    drive("low_dn",     1,0,0, 8'd0, 8'd5,  2'b00, 0, 8'd7, 2'd2, 0, 0);

    // async reset mid-run
    drive("ar_load",    0,1,1, 8'd6, 8'd20, 2'b00, 1, 8'd6, 2'd0, 0, 0);
    drive("ar_up7",     1,1,0, 8'd0, 8'd20, 2'b00, 0, 8'd7, 2'd1, 0, 0);
    #2 reset = 1'b1;
    #1 compare("async_reset", {count, state, tc, ovflw}, {8'd0, 2'd0, 1'b0, 1'b0});
    #1 reset = 1'b0;
    drive("ar_resume",  1,1,0, 8'd0, 8'd20, 2'b00, 0, 8'd1, 2'd1, 0, 0);
    drive("ar_dn",      1,0,0, 8'd0, 8'd20, 2'b00, 0, 8'd0, 2'd2, 0, 0);
    drive("ar_idle",    0,0,0, 8'd0, 8'd20, 2'b00, 0, 8'd0, 2'd0, 0, 0);

    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      #2;
      if (exp_q.size() > 0) begin
        n_vec++;
        n_err++;
        $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_fsm_mod.md
# counter_fsm_mod

Parametrised up/down counter with an FSM controller. Adds a programmable terminal value, synchronous load, and selectable boundary behaviour (wrap, saturate or trap). Boundary events raise a sticky overflow flag and a one-cycle terminal-count pulse. It is the general-purpose event/interval counter for control paths that need more than a fixed power-of-two up/down counter with a permanent overflow lock.

## Interface
Parameters:
- N, 8, counter width in bits (N ≥ 2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  step enable; one step per cycle while high
- up_dn  in  1  direction: 1 = up, 0 = down
- load  in  1  synchronous load of load_val
- load_val  in  N  value to load
- limit  in  N  terminal value; count range is 0..limit
- mode  in  2  boundary behaviour: 00 wrap, 01 saturate, 10 trap, 11 treated as 00
- clr_ovf  in  1  clears ovflw; releases TRAP
- count  out  N  current count (registered)
- state  out  2  FSM state: 0 IDLE, 1 UP, 2 DOWN, 3 TRAP
- tc  out  1  one-cycle pulse on a boundary event
- ovflw  out  1  sticky boundary flag

## Operation
- All outputs are registered. Reset values: count 0, state IDLE, tc 0, ovflw 0.
- Per-edge priority: reset > load > TRAP hold > en step > idle.
- load:
  - count <= min(load_val, limit); state <= IDLE; tc <= 0.
  - Legal in any state, including TRAP; leaves ovflw unchanged unless clr_ovf is also high.
- State update when not loading and not in TRAP:
  - en = 0: state <= IDLE, count held.
  - en = 1, up_dn = 1: state <= UP.
  - en = 1, up_dn = 0: state <= DOWN.
- Up step:
  - count < limit: count + 1.
  - count ≥ limit (boundary): mode 00 → 0; mode 01 → limit; mode 10 → limit and state <= TRAP.
- Down step:
  - count > 0: count − 1.
  - count == 0 (boundary): mode 00 → limit; mode 01 → 0; mode 10 → 0 and state <= TRAP.
- Boundary event: tc <= 1 for that edge only; ovflw <= 1.
- TRAP:
  - count frozen; en and up_dn ignored; tc 0.
  - Exits to IDLE on clr_ovf or load.
- clr_ovf: ovflw <= 0, except when a boundary event occurs on the same edge, in which case set wins (ovflw stays 1).
- Arithmetic is N-bit unsigned. Internal +1 and −1 never wrap silently; all wrapping goes through the boundary rule.
- limit == 0: count stays 0; every enabled step is a boundary event.
- limit lowered below count at run time: the next up step is a boundary; a down step decrements normally.
- mode and limit changes take effect on the next edge that samples them.

## Timing
- Step latency: en sampled on edge k; count, state and tc reflect that step after edge k.
- tc is high for exactly one cycle per boundary event. Continuous saturation (mode 01, en held at the boundary) pulses tc every cycle.
- ovflw rises on the same edge as tc and holds until clr_ovf.
- reset asserted mid-count forces all outputs to reset values immediately, without waiting for clk. Counting resumes on the first edge after reset deasserts.
- No combinational path from any input to any output.

## Test plan
- Wrap up: N=8, limit=5, mode 00, load 0, en=1 up for 7 cycles → count 1,2,3,4,5,0,1; tc high only on the edge count goes 5→0; ovflw 1 from that edge onward.
- Saturate down: limit=9, mode 01, load 3, en=1 down for 5 cycles → count 2,1,0,0,0; tc high on the 4th and 5th edges; state DOWN throughout.
- Trap and release: limit=3, mode 10, count 2, up for 4 cycles → count 3, then 3 held with state TRAP; en ignored; clr_ovf → state IDLE, ovflw 0, next up step → boundary again.
- Load clamp and priority: limit=10, load_val=200 with load=1 and en=1 on the same edge → count 10, state IDLE, tc 0; load in TRAP with load_val 4 → count 4, state IDLE, ovflw still 1.
- Clear/set collision: ovflw=1, clr_ovf high on the same edge as a boundary event → ovflw stays 1; clr_ovf on a later non-boundary edge → ovflw 0.
- Async reset mid-run: mode 00, counting up at count 7, reset pulse between edges → count 0, state IDLE, tc 0, ovflw 0 before the next edge; counting resumes from 0 → 1 after release.
